// File: rtl/obstacle_scheduler.sv
// Obstacle column/lane scheduler for the LCD runner game.
// Steps an obstacle right-to-left once every STEP_CYCLES clocks and picks new lanes with an LFSR.
module obstacle_scheduler #(
    parameter logic [23:0] STEP_CYCLES = 24'd1000000,
    parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       pause,
    input  logic       stop,
    output logic [3:0] pos,
    output logic       zero_top_one_bottom,
    output logic       next,
    output logic       passed,
    output logic [7:0] passed_count,
    output logic       busy
);

    typedef enum logic [1:0] {StIdle, StRun, StPaused, StStopped} state_e;

    state_e      state_q, state_d;
    logic [23:0] cnt_q, cnt_d;
    logic [3:0]  pos_q, pos_d;
    logic        lane_q, lane_d;
    logic [7:0]  pcount_q, pcount_d;
    logic [7:0]  lfsr_q, lfsr_d;
    logic        upd_q, upd_d;
    logic        next_q, next_d;
    logic        passed_q, passed_d;
    logic        lfsr_fb;

    // Taps 8,6,5,4 of a left-shifting Fibonacci register.
    assign lfsr_fb = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pos_d    = pos_q;
        lane_d   = lane_q;
        pcount_d = pcount_q;
        lfsr_d   = {lfsr_q[6:0], lfsr_fb};
        upd_d    = 1'b0;
        // upd_q marks the cycle the new frame becomes visible; next follows it by one cycle.
        next_d   = upd_q;
        passed_d = 1'b0;

        unique case (state_q)
            StIdle, StStopped: begin
                if (start && !(state_q == StStopped && stop)) begin
                    state_d  = StRun;
                    pos_d    = 4'hF;
                    lane_d   = lfsr_q[0];
                    pcount_d = 8'd0;
                    cnt_d    = 24'd0;
                    upd_d    = 1'b1;
                end
            end
            StRun, StPaused: begin
                if (stop) begin
                    state_d = StStopped;
                end else if (pause) begin
                    state_d = StPaused;
                end else begin
                    // The resume cycle counts too, so a pause of N cycles delays by exactly N.
                    state_d = StRun;
                    if (cnt_q == STEP_CYCLES - 24'd1) begin
                        cnt_d = 24'd0;
                        upd_d = 1'b1;
                        if (pos_q == 4'h0) begin
                            pos_d    = 4'hF;
                            lane_d   = lfsr_q[0];
                            passed_d = 1'b1;
                            if (pcount_q != 8'hFF) begin
                                pcount_d = pcount_q + 8'd1;
                            end
                        end else begin
                            pos_d = pos_q - 4'd1;
                        end
                    end else begin
                        cnt_d = cnt_q + 24'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= 24'd0;
            pos_q    <= 4'hF;
            lane_q   <= 1'b1;
            pcount_q <= 8'd0;
            lfsr_q   <= LFSR_SEED;
            upd_q    <= 1'b0;
            next_q   <= 1'b0;
            passed_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pos_q    <= pos_d;
            lane_q   <= lane_d;
            pcount_q <= pcount_d;
            lfsr_q   <= lfsr_d;
            upd_q    <= upd_d;
            next_q   <= next_d;
            passed_q <= passed_d;
        end
    end

    assign pos                 = pos_q;
    assign zero_top_one_bottom = lane_q;
    assign next                = next_q;
    assign passed              = passed_q;
    assign passed_count        = pcount_q;
    assign busy                = (state_q == StRun) || (state_q == StPaused);

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Self-checking bench for obstacle_scheduler: vector table, corner sequences and a random run
// compared every cycle against a behavioural model.
module tb_obstacle_scheduler;

    localparam logic [23:0] STEP = 24'd16;
    localparam logic [7:0]  SEED = 8'hA5;

    logic       clk = 1'b0;
    logic       rst, start, pause, stop;
    logic [3:0] pos;
    logic       lane, next, passed, busy;
    logic [7:0] passed_count;

    int checks = 0;
    int errors = 0;

    obstacle_scheduler #(
        .STEP_CYCLES(STEP),
        .LFSR_SEED  (SEED)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .start              (start),
        .pause              (pause),
        .stop               (stop),
        .pos                (pos),
        .zero_top_one_bottom(lane),
        .next               (next),
        .passed             (passed),
        .passed_count       (passed_count),
        .busy               (busy)
    );

    always #5 clk = ~clk;

    // Behavioural model: mode 0 idle, 1 running, 2 paused, 3 stopped.
    int         m_mode, m_cnt;
    logic [3:0] m_pos;
    logic       m_lane, m_next, m_shown, m_passed;
    logic [7:0] m_pc, m_lfsr;

    task automatic model_reset();
        m_mode = 0; m_cnt = 0; m_pos = 4'hF; m_lane = 1'b1; m_next = 1'b0;
        m_shown = 1'b0; m_passed = 1'b0; m_pc = 8'd0; m_lfsr = SEED;
    endtask

    task automatic model_edge();
        logic pick;
        if (rst) begin
            model_reset();
            return;
        end
        pick = m_lfsr[0];
        m_next = m_shown;
        m_shown = 1'b0;
        m_passed = 1'b0;
        if (m_mode == 0 || m_mode == 3) begin
            if (start && !(m_mode == 3 && stop)) begin
                m_mode = 1; m_pos = 4'hF; m_lane = pick; m_pc = 8'd0; m_cnt = 0; m_shown = 1'b1;
            end
        end else if (stop) begin
            m_mode = 3;
        end else if (pause) begin
            m_mode = 2;
        end else begin
            m_mode = 1;
            m_cnt = m_cnt + 1;
            if (m_cnt == int'(STEP)) begin
                m_cnt = 0;
                m_shown = 1'b1;
                if (m_pos == 0) begin
                    m_pos = 4'hF; m_lane = pick; m_passed = 1'b1;
                    if (m_pc < 255) m_pc = m_pc + 1;
                end else begin
                    m_pos = m_pos - 1;
                end
            end
        end
        m_lfsr = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    task automatic check_model();
        logic m_busy;
        m_busy = (m_mode == 1 || m_mode == 2);
        check("model {pos,lane,next,passed,count,busy}",
              {16'd0, pos, lane, next, passed, passed_count, busy},
              {16'd0, m_pos, m_lane, m_next, m_passed, m_pc, m_busy});
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_model();
    endtask

    task automatic async_reset_pulse();
        #2 rst = 1'b1;
        #1;
        check("reset outputs", {16'd0, pos, lane, next, passed, passed_count, busy},
              {16'd0, 4'hF, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0});
        model_reset();
        tick();
        rst = 1'b0;
    endtask

    typedef struct {
        logic       start, pause, stop;
        int         extra;
        logic [3:0] pos;
        logic       next, busy;
        logic [7:0] pc;
    } vec_t;

    vec_t vt[9];

    initial begin
        int   n, saved, got;
        logic seen;

        // Each row: drive inputs for one cycle, idle 'extra' cycles, then compare.
        vt[0] = '{1'b1, 1'b0, 1'b0, 1,  4'hF, 1'b1, 1'b1, 8'h00};
        vt[1] = '{1'b0, 1'b0, 1'b0, 15, 4'hE, 1'b1, 1'b1, 8'h00};
        vt[2] = '{1'b0, 1'b0, 1'b0, 15, 4'hD, 1'b1, 1'b1, 8'h00};
        vt[3] = '{1'b1, 1'b0, 1'b0, 15, 4'hC, 1'b1, 1'b1, 8'h00};
        vt[4] = '{1'b0, 1'b0, 1'b1, 0,  4'hC, 1'b0, 1'b0, 8'h00};
        vt[5] = '{1'b1, 1'b0, 1'b1, 3,  4'hC, 1'b0, 1'b0, 8'h00};
        vt[6] = '{1'b1, 1'b0, 1'b0, 1,  4'hF, 1'b1, 1'b1, 8'h00};
        vt[7] = '{1'b0, 1'b1, 1'b0, 0,  4'hF, 1'b0, 1'b1, 8'h00};
        vt[8] = '{1'b0, 1'b0, 1'b0, 15, 4'hE, 1'b1, 1'b1, 8'h00};

        rst = 1'b1; start = 1'b0; pause = 1'b0; stop = 1'b0;
        model_reset();
        repeat (3) tick();
        rst = 1'b0;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (next) n++;
        end
        check("no next before start", n, 0);

        for (int i = 0; i < 9; i++) begin
            start = vt[i].start; pause = vt[i].pause; stop = vt[i].stop;
            tick();
            start = 1'b0; pause = 1'b0; stop = 1'b0;
            for (int k = 0; k < vt[i].extra; k++) tick();
            check($sformatf("vec%0d {pos,next,busy,count}", i),
                  {20'd0, pos, next, busy, passed_count},
                  {20'd0, vt[i].pos, vt[i].next, vt[i].busy, vt[i].pc});
        end

        // Pause at counter 5 for 40 cycles: next lands 12 cycles after release, one step on.
        repeat (4) tick();
        saved = pos;
        pause = 1'b1;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (next || passed) n++;
        end
        check("no next while paused", n, 0);
        pause = 1'b0;
        got = -1;
        for (int i = 1; i <= 40 && got < 0; i++) begin
            tick();
            if (next) got = i;
        end
        check("resume latency", got, 12);
        check("pos after resume", pos, saved - 1);

        // Stop coinciding with a step event.
        saved = pos;
        repeat (14) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("stop vs step {pos,busy,passed}", {pos, busy, passed}, {saved[3:0], 1'b0, 1'b0});
        n = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (next) n++;
        end
        check("no next after stop", n, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart {pos,count}", {pos, passed_count}, {4'hF, 8'h00});
        tick();
        check("restart next", next, 1'b1);

        // First wrap past column 0.
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            tick();
            seen = passed;
        end
        check("passed seen", seen, 1'b1);
        check("wrap {pos,lane,count}", {pos, lane, passed_count}, {4'hF, m_lane, 8'h01});
        tick();
        check("next after passed", next, 1'b1);

        // Saturation of passed_count.
        for (int i = 0; i < 66000 && passed_count != 8'hFF; i++) tick();
        check("count reaches FF", passed_count, 8'hFF);
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            tick();
            seen = passed;
        end
        check("passed after saturation", seen, 1'b1);
        check("count holds FF", passed_count, 8'hFF);

        // Asynchronous reset mid-run, then stay idle.
        repeat (5) tick();
        async_reset_pulse();
        n = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (next) n++;
        end
        check("idle after reset", n, 0);

        // Random control traffic, compared against the model every cycle.
        for (int i = 0; i < 3000; i++) begin
            start = ($urandom % 20) == 0;
            pause = ($urandom % 12) == 0;
            stop  = ($urandom % 80) == 0;
            tick();
            if (($urandom % 600) == 0) async_reset_pulse();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
